adma_desc_sequencer: RTL and testbench

Descriptor-level sequencer for the SD host ADMA2 engine. It walks the descriptor table in system memory through the ST_STOP / ST_FDS / ST_CADR / ST_TFR states, fetching one 64-bit descriptor at a time and decoding its attributes. Each "tran" descriptor becomes one transfer request to the data path. It sits between the command/control registers and the DMA data mover, and reports ADMA errors and descriptor interrupts to the interrupt logic.

---
 rtl/adma_desc_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_adma_desc_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_desc_sequencer.sv
// adma_desc_sequencer
//   Walks an ADMA2 descriptor table one 64-bit descriptor at a time
//   (ST_STOP -> ST_FDS -> ST_CADR -> ST_TFR) and turns each tran
//   descriptor into a single transfer request for the data mover.
//
// Ports
//   CLK, RESET_n          clock, async active-low reset
//   start, stop_req       walk start pulse / host abort (abort wins)
//   adma_base_addr        first descriptor pointer
//   desc_rd_*             descriptor fetch handshake (req held until ack)
//   xfer_*                transfer launch pulse, buffer addr/len, done
//   adma_sys_addr         current descriptor pointer
//   busy                  not in ST_STOP
//   adma_error_int/state  sticky invalid-descriptor error and its state
//   dma_int               one-cycle pulse when an Int=1 descriptor retires
module adma_desc_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              start,
  input  logic              stop_req,
  input  logic [ADDR_W-1:0] adma_base_addr,
  output logic              desc_rd_req,
  output logic [ADDR_W-1:0] desc_rd_addr,
  input  logic              desc_rd_ack,
  input  logic [63:0]       desc_rd_data,
  output logic              xfer_start,
  output logic [ADDR_W-1:0] xfer_addr,
  output logic [16:0]       xfer_len,
  input  logic              xfer_done,
  output logic [ADDR_W-1:0] adma_sys_addr,
  output logic              busy,
  output logic              adma_error_int,
  output logic [1:0]        adma_error_state,
  output logic              dma_int
);

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_FDS  = 2'b01,
    ST_CADR = 2'b10,
    ST_TFR  = 2'b11
  } state_t;

  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  // Only the decoded descriptor fields are kept.
  logic [31:0]         d_addr_q, d_addr_d;
  logic [15:0]         d_len_q, d_len_d;
  logic [1:0]          d_act_q, d_act_d;
  logic                d_int_q, d_int_d;
  logic                d_end_q, d_end_d;
  logic [ADDR_W-1:0]   xaddr_q, xaddr_d;
  logic [16:0]         xlen_q, xlen_d;
  logic                xstart_q, xstart_d;
  logic                rdreq_q, rdreq_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [1:0]          errst_q, errst_d;
  logic                dint_q, dint_d;

  // Reserved descriptor bits carry no meaning here.
  logic                desc_unused;
  assign desc_unused = ^{desc_rd_data[15:6], desc_rd_data[3]};

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= ST_STOP;
      ptr_q    <= '0;
      d_addr_q <= '0;
      d_len_q  <= '0;
      d_act_q  <= '0;
      d_int_q  <= 1'b0;
      d_end_q  <= 1'b0;
      xaddr_q  <= '0;
      xlen_q   <= '0;
      xstart_q <= 1'b0;
      rdreq_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      errst_q  <= 2'b00;
      dint_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      d_addr_q <= d_addr_d;
      d_len_q  <= d_len_d;
      d_act_q  <= d_act_d;
      d_int_q  <= d_int_d;
      d_end_q  <= d_end_d;
      xaddr_q  <= xaddr_d;
      xlen_q   <= xlen_d;
      xstart_q <= xstart_d;
      rdreq_q  <= rdreq_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      errst_q  <= errst_d;
      dint_q   <= dint_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    d_addr_d = d_addr_q;
    d_len_d  = d_len_q;
    d_act_d  = d_act_q;
    d_int_d  = d_int_q;
    d_end_d  = d_end_q;
    xaddr_d  = xaddr_q;
    xlen_d   = xlen_q;
    xstart_d = 1'b0;
    err_d    = err_q;
    errst_d  = errst_q;
    dint_d   = 1'b0;

    case (state_q)
      ST_STOP: begin
        if (start) begin
          ptr_d   = adma_base_addr;
          err_d   = 1'b0;
          errst_d = 2'b00;
          state_d = ST_FDS;
        end
      end
      ST_FDS: begin
        if (desc_rd_ack) begin
          d_addr_d = desc_rd_data[63:32];
          d_len_d  = desc_rd_data[31:16];
          d_act_d  = desc_rd_data[5:4];
          d_int_d  = desc_rd_data[2];
          d_end_d  = desc_rd_data[1];
          if (!desc_rd_data[0]) begin
            // Pointer stays on the faulty descriptor for software.
            err_d   = 1'b1;
            errst_d = 2'b01;
            state_d = ST_STOP;
          end else begin
            state_d = ST_CADR;
          end
        end
      end
      ST_CADR: begin
        if (d_act_q == ACT_TRAN) begin
          ptr_d    = ptr_q + ADDR_W'(8);
          xaddr_d  = ADDR_W'(d_addr_q);
          // Zero length encodes a full 64 KiB buffer.
          xlen_d   = (d_len_q == 16'h0) ? 17'h10000 : {1'b0, d_len_q};
          xstart_d = 1'b1;
          state_d  = ST_TFR;
        end else begin
          ptr_d   = (d_act_q == ACT_LINK) ? ADDR_W'(d_addr_q) : ptr_q + ADDR_W'(8);
          dint_d  = d_int_q;
          state_d = d_end_q ? ST_STOP : ST_FDS;
        end
      end
      ST_TFR: begin
        if (xfer_done) begin
          dint_d  = d_int_q;
          state_d = d_end_q ? ST_STOP : ST_FDS;
        end
      end
      default: state_d = ST_STOP;
    endcase

    // Abort overrides everything: no launch, no interrupt, no error.
    if (stop_req) begin
      state_d  = ST_STOP;
      xstart_d = 1'b0;
      dint_d   = 1'b0;
      err_d    = err_q;
      errst_d  = errst_q;
    end

    rdreq_d = (state_d == ST_FDS);
    busy_d  = (state_d != ST_STOP);
  end

  assign desc_rd_req      = rdreq_q;
  assign desc_rd_addr     = ptr_q;
  assign adma_sys_addr    = ptr_q;
  assign xfer_start       = xstart_q;
  assign xfer_addr        = xaddr_q;
  assign xfer_len         = xlen_q;
  assign busy             = busy_q;
  assign adma_error_int   = err_q;
  assign adma_error_state = errst_q;
  assign dma_int          = dint_q;

endmodule

// File: tb/tb_adma_desc_sequencer.sv
// Bench for adma_desc_sequencer: a descriptor memory responder and a data
// mover model; expected fetch addresses and transfers are queued when a
// scenario is set up and compared when the DUT issues them.
module tb_adma_desc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        start, stop_req;
  logic [31:0] adma_base_addr;
  logic        desc_rd_req;
  logic [31:0] desc_rd_addr;
  logic        desc_rd_ack;
  logic [63:0] desc_rd_data;
  logic        xfer_start;
  logic [31:0] xfer_addr;
  logic [16:0] xfer_len;
  logic        xfer_done;
  logic [31:0] adma_sys_addr;
  logic        busy;
  logic        adma_error_int;
  logic [1:0]  adma_error_state;
  logic        dma_int;

  adma_desc_sequencer #(.ADDR_W(32)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .start(start), .stop_req(stop_req),
    .adma_base_addr(adma_base_addr), .desc_rd_req(desc_rd_req),
    .desc_rd_addr(desc_rd_addr), .desc_rd_ack(desc_rd_ack),
    .desc_rd_data(desc_rd_data), .xfer_start(xfer_start),
    .xfer_addr(xfer_addr), .xfer_len(xfer_len), .xfer_done(xfer_done),
    .adma_sys_addr(adma_sys_addr), .busy(busy),
    .adma_error_int(adma_error_int), .adma_error_state(adma_error_state),
    .dma_int(dma_int)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [63:0] mem [int unsigned];
  logic [31:0] exp_rd_q[$];
  logic [48:0] exp_xfer_q[$];   // {addr, len}

  int xs_cnt = 0, dint_cnt = 0, dint_cyc = -1, done_cyc = -1;
  bit rd_hold = 0, mv_hold = 0, mv_pending = 0;
  int rd_cnt = 0, mv_cnt = 0;

  function automatic logic [63:0] mk(input logic [31:0] a, input logic [15:0] l,
                                     input logic [1:0] act, input logic i,
                                     input logic e, input logic v);
    return {a, l, 10'b0, act, 1'b0, i, e, v};
  endfunction

  // Descriptor memory: acks one cycle after the request is seen.
  initial begin
    desc_rd_ack = 0; desc_rd_data = '0;
    forever begin
      @(posedge CLK); #1;
      if (desc_rd_req === 1'b1 && !desc_rd_ack && !rd_hold) begin
        if (rd_cnt >= 1) begin
          n_checks++;
          if (exp_rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_addr: fetch at %h, none expected", desc_rd_addr);
          end else begin
            logic [31:0] e;
            e = exp_rd_q.pop_front();
            if (desc_rd_addr !== e) begin
              n_fail++;
              $display("FAIL rd_addr: got %h, expected %h", desc_rd_addr, e);
            end
          end
          desc_rd_data = mem.exists(desc_rd_addr) ? mem[desc_rd_addr] : 64'h0;
          desc_rd_ack  = 1;
          rd_cnt       = 0;
        end else rd_cnt++;
      end else desc_rd_ack = 0;
    end
  end

  // Data mover: done two cycles after the launch pulse unless held.
  initial begin
    xfer_done = 0;
    forever begin
      @(posedge CLK); #1;
      xfer_done = 0;
      if (xfer_start === 1'b1) begin
        xs_cnt++;
        n_checks++;
        if (exp_xfer_q.size() == 0) begin
          n_fail++;
          $display("FAIL xfer: got addr %h len %h, none expected", xfer_addr, xfer_len);
        end else begin
          logic [48:0] e;
          e = exp_xfer_q.pop_front();
          if ({xfer_addr, xfer_len} !== e) begin
            n_fail++;
            $display("FAIL xfer: got addr %h len %h, expected addr %h len %h",
                     xfer_addr, xfer_len, e[48:17], e[16:0]);
          end
        end
        mv_pending = 1; mv_cnt = 0;
      end else if (mv_pending && !mv_hold) begin
        mv_cnt++;
        if (mv_cnt == 2) begin
          xfer_done = 1; mv_pending = 0; done_cyc = cyc;
        end
      end
    end
  end

  always @(negedge CLK) if (RESET_n && dma_int === 1'b1) begin
    dint_cnt = dint_cnt + 1;
    dint_cyc = cyc;
  end

  task automatic pulse_start(input logic [31:0] base);
    adma_base_addr = base;
    @(posedge CLK); #1; start = 1;
    @(posedge CLK); #1; start = 0;
  endtask

  task automatic run_walk(output int low_cyc);
    bit done;
    done = 0; low_cyc = -1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge CLK); #1;
      if (!busy) begin done = 1; low_cyc = cyc; end
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL walk_timeout: busy still %b, expected 0", busy); end
  endtask

  task automatic test_reset();
    RESET_n = 0; start = 0; stop_req = 0; adma_base_addr = '0;
    repeat (3) @(posedge CLK);
    #2;
    n_checks++; if (busy !== 1'b0 || desc_rd_req !== 1'b0) begin n_fail++;
      $display("FAIL rst_ctl: busy %b req %b, expected 0 0", busy, desc_rd_req); end
    @(negedge CLK); RESET_n = 1;
    repeat (2) @(posedge CLK); #1;
    n_checks++; if ({xfer_start, dma_int, adma_error_int, adma_error_state} !== 5'b0) begin n_fail++;
      $display("FAIL rst_flags: got %b, expected 00000", {xfer_start, dma_int, adma_error_int, adma_error_state}); end
    n_checks++; if (adma_sys_addr !== 32'h0 || desc_rd_addr !== 32'h0) begin n_fail++;
      $display("FAIL rst_ptr: got %h/%h, expected 0", adma_sys_addr, desc_rd_addr); end
    n_checks++; if (xfer_addr !== 32'h0 || xfer_len !== 17'h0) begin n_fail++;
      $display("FAIL rst_xfer: got %h/%h, expected 0", xfer_addr, xfer_len); end
  endtask

  task automatic test_single_tran();
    int lc, xs0;
    mem.delete();
    mem[32'h1000] = mk(32'h8000, 16'h0200, 2'b10, 0, 1, 1);
    exp_rd_q.push_back(32'h1000);
    exp_xfer_q.push_back({32'h8000, 17'h00200});
    xs0 = xs_cnt;
    pulse_start(32'h1000);
    n_checks++; if (busy !== 1'b1 || desc_rd_req !== 1'b1) begin n_fail++;
      $display("FAIL start_latency: busy %b req %b, expected 1 1", busy, desc_rd_req); end
    run_walk(lc);
    n_checks++; if (xs_cnt - xs0 != 1) begin n_fail++;
      $display("FAIL single_xs: got %0d starts, expected 1", xs_cnt - xs0); end
    n_checks++; if (adma_sys_addr !== 32'h1008 || adma_error_int !== 1'b0) begin n_fail++;
      $display("FAIL single_end: ptr %h err %b, expected 00001008 0", adma_sys_addr, adma_error_int); end
    n_checks++; if (lc != done_cyc + 1) begin n_fail++;
      $display("FAIL single_busy_drop: cycle %0d, expected %0d", lc, done_cyc + 1); end
  endtask

  task automatic test_chain();
    int lc, xs0;
    mem.delete();
    mem[32'h1000] = mk(32'h0, 16'h0, 2'b00, 0, 0, 1);
    mem[32'h1008] = mk(32'h2000, 16'h0, 2'b11, 0, 0, 1);
    mem[32'h2000] = mk(32'h9000, 16'h0010, 2'b10, 0, 1, 1);
    exp_rd_q.push_back(32'h1000); exp_rd_q.push_back(32'h1008); exp_rd_q.push_back(32'h2000);
    exp_xfer_q.push_back({32'h9000, 17'h00010});
    xs0 = xs_cnt;
    pulse_start(32'h1000);
    run_walk(lc);
    n_checks++; if (xs_cnt - xs0 != 1 || exp_rd_q.size() != 0) begin n_fail++;
      $display("FAIL chain: starts %0d reads left %0d, expected 1 0", xs_cnt - xs0, exp_rd_q.size()); end
    n_checks++; if (adma_sys_addr !== 32'h2008) begin n_fail++;
      $display("FAIL chain_ptr: got %h, expected 00002008", adma_sys_addr); end
  endtask

  task automatic test_invalid();
    int lc, xs0;
    mem.delete();
    mem[32'h1000] = mk(32'h0, 16'h0, 2'b00, 0, 0, 1);
    mem[32'h1008] = mk(32'h8000, 16'h0100, 2'b10, 0, 1, 0);
    exp_rd_q.push_back(32'h1000); exp_rd_q.push_back(32'h1008);
    xs0 = xs_cnt;
    pulse_start(32'h1000);
    run_walk(lc);
    n_checks++; if (adma_error_int !== 1'b1 || adma_error_state !== 2'b01) begin n_fail++;
      $display("FAIL inv_err: got %b/%b, expected 1/01", adma_error_int, adma_error_state); end
    n_checks++; if (adma_sys_addr !== 32'h1008 || xs_cnt != xs0) begin n_fail++;
      $display("FAIL inv_ptr: ptr %h starts %0d, expected 00001008 0", adma_sys_addr, xs_cnt - xs0); end
    mem[32'h3000] = mk(32'hC000, 16'h0008, 2'b10, 0, 1, 1);
    exp_rd_q.push_back(32'h3000);
    exp_xfer_q.push_back({32'hC000, 17'h00008});
    pulse_start(32'h3000);
    n_checks++; if (adma_error_int !== 1'b0 || adma_error_state !== 2'b00) begin n_fail++;
      $display("FAIL inv_clear: got %b/%b, expected 0/00", adma_error_int, adma_error_state); end
    run_walk(lc);
  endtask

  task automatic test_len0_int();
    int lc, d0;
    mem.delete();
    mem[32'h4000] = mk(32'hA000, 16'h0000, 2'b10, 1, 1, 1);
    exp_rd_q.push_back(32'h4000);
    exp_xfer_q.push_back({32'hA000, 17'h10000});
    d0 = dint_cnt;
    pulse_start(32'h4000);
    run_walk(lc);
    repeat (2) @(posedge CLK);
    n_checks++; if (dint_cnt - d0 != 1) begin n_fail++;
      $display("FAIL len0_dint_cnt: got %0d, expected 1", dint_cnt - d0); end
    n_checks++; if (dint_cyc != done_cyc + 1) begin n_fail++;
      $display("FAIL len0_dint_time: cycle %0d, expected %0d", dint_cyc, done_cyc + 1); end
  endtask

  task automatic test_stop();
    int xs0;
    bit seen;
    mem.delete();
    mem[32'h5000] = mk(32'hB000, 16'h0040, 2'b10, 0, 0, 1);
    mem[32'h6000] = mk(32'hD000, 16'h0040, 2'b10, 0, 1, 1);
    exp_rd_q.push_back(32'h5000);
    exp_xfer_q.push_back({32'hB000, 17'h00040});
    mv_hold = 1;
    xs0 = xs_cnt;
    pulse_start(32'h5000);
    // A second start while busy, pointing elsewhere, must be ignored.
    adma_base_addr = 32'h6000; start = 1;
    @(posedge CLK); #1; start = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      if (xs_cnt != xs0) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL stop_no_xfer: starts 0, expected 1"); end
    @(posedge CLK);
    @(posedge CLK); #1; stop_req = 1;
    @(posedge CLK); #1; stop_req = 0;
    n_checks++; if (busy !== 1'b0 || desc_rd_req !== 1'b0 || adma_error_int !== 1'b0) begin n_fail++;
      $display("FAIL stop_state: busy %b req %b err %b, expected 0 0 0", busy, desc_rd_req, adma_error_int); end
    n_checks++; if (adma_sys_addr !== 32'h5008) begin n_fail++;
      $display("FAIL stop_ptr: got %h, expected 00005008", adma_sys_addr); end
    mv_pending = 0; mv_hold = 0;
    adma_base_addr = 32'h6000;
    @(posedge CLK); #1; start = 1; stop_req = 1;
    @(posedge CLK); #1; start = 0; stop_req = 0;
    n_checks++; if (busy !== 1'b0 || desc_rd_req !== 1'b0) begin n_fail++;
      $display("FAIL stop_start: busy %b req %b, expected 0 0", busy, desc_rd_req); end
  endtask

  task automatic test_reset_mid_fds();
    mem.delete();
    rd_hold = 1;
    pulse_start(32'h7000);
    @(posedge CLK); #2;
    RESET_n = 0;
    #1;
    n_checks++; if (desc_rd_req !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rstfds_ctl: req %b busy %b, expected 0 0", desc_rd_req, busy); end
    n_checks++; if (adma_sys_addr !== 32'h0 || {xfer_addr, xfer_len} !== 49'h0) begin n_fail++;
      $display("FAIL rstfds_regs: ptr %h xaddr %h xlen %h, expected 0", adma_sys_addr, xfer_addr, xfer_len); end
    @(negedge CLK); RESET_n = 1; rd_hold = 0;
    repeat (5) @(posedge CLK); #1;
    n_checks++; if (busy !== 1'b0 || desc_rd_req !== 1'b0) begin n_fail++;
      $display("FAIL rstfds_idle: busy %b req %b, expected 0 0", busy, desc_rd_req); end
  endtask

  initial begin
    test_reset();
    test_single_tran();
    test_chain();
    test_invalid();
    test_len0_int();
    test_stop();
    test_reset_mid_fds();
    n_checks++; if (exp_rd_q.size() != 0 || exp_xfer_q.size() != 0) begin n_fail++;
      $display("FAIL sb_drain: reads %0d xfers %0d left, expected 0 0", exp_rd_q.size(), exp_xfer_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
